// File: rtl/imm_splitter.sv
// Purpose: narrows a 32-bit constant into the shortest ADDI / ORI / LUI(+ORI) immediate-field sequence.
// Latency: first beat valid the cycle after acceptance; in_ready returns the cycle after the last beat is taken.
// Backpressure: out_ready low stalls the FSM with out_imm/out_kind/out_last held; in_ready is low while beats are pending.
//
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid/in_ready/in_value  : 32-bit constant input handshake
//   out_valid/out_ready         : immediate-beat output handshake
//   out_imm/out_kind/out_last   : 16-bit field, 00=ADDI 01=LUI 10=ORI, final-beat flag
//   split_cnt                   : saturating count of values that needed an LUI
module imm_splitter #(
    parameter bit ZEXT_EN = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_kind,
    output logic             out_last,
    output logic [CNT_W-1:0] split_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT1 = 2'd1,
        EMIT2 = 2'd2
    } state_t;

    localparam logic [1:0] KIND_ADDI = 2'b00;
    localparam logic [1:0] KIND_LUI  = 2'b01;
    localparam logic [1:0] KIND_ORI  = 2'b10;

    state_t           state_q, state_d;
    logic [31:0]      value_q, value_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_imm_q, out_imm_d;
    logic [1:0]       out_kind_q, out_kind_d;
    logic             out_last_q, out_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic sfit;
    logic zfit;
    logic low_zero;

    // Classification of the value being captured into value_q. Beat 1 is
    // loaded into the output flops on the capture edge so that out_* stay
    // purely registered.
    always_comb begin
        sfit     = (in_value[31:15] == {17{in_value[15]}});
        zfit     = ZEXT_EN && (in_value[31:16] == 16'h0000);
        low_zero = (in_value[15:0] == 16'h0000);
    end

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        out_kind_d  = out_kind_q;
        out_last_d  = out_last_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    value_d     = in_value;
                    state_d     = EMIT1;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    if (sfit) begin
                        out_kind_d = KIND_ADDI;
                        out_imm_d  = in_value[15:0];
                        out_last_d = 1'b1;
                    end else if (zfit) begin
                        out_kind_d = KIND_ORI;
                        out_imm_d  = in_value[15:0];
                        out_last_d = 1'b1;
                    end else begin
                        // UPONLY finishes with the LUI; FULL needs a trailing ORI.
                        out_kind_d = KIND_LUI;
                        out_imm_d  = in_value[31:16];
                        out_last_d = low_zero;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            EMIT1: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d    = EMIT2;
                        out_kind_d = KIND_ORI;
                        out_imm_d  = value_q[15:0];
                        out_last_d = 1'b1;
                    end
                end
            end
            EMIT2: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            value_q     <= 32'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_imm_q   <= 16'h0;
            out_kind_q  <= KIND_ADDI;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_kind_q  <= out_kind_d;
            out_last_q  <= out_last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_kind  = out_kind_q;
    assign out_last  = out_last_q;
    assign split_cnt = cnt_q;

endmodule

// File: tb/tb_imm_splitter.sv
// Purpose: self-checking bench for imm_splitter; instance 0 has ZEXT_EN=1, instance 1 has ZEXT_EN=0, both CNT_W=2.
// Latency: expects first beat one cycle after acceptance and in_ready one cycle after the last beat.
// Backpressure: random out_ready stalls with field-stability checks; in_valid pulsed while busy must be ignored.
module tb_imm_splitter;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_value  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] out_imm   [2];
    logic [1:0]  out_kind  [2];
    logic        out_last  [2];
    logic [1:0]  split_cnt [2];

    int n_vec;
    int n_bad;
    int cnt_model [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : u
            imm_splitter #(
                .ZEXT_EN (g == 0),
                .CNT_W   (2)
            ) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_value  (in_value[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_imm   (out_imm[g]),
                .out_kind  (out_kind[g]),
                .out_last  (out_last[g]),
                .split_cnt (split_cnt[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the shortest legal encoding, derived from value ranges.
    task automatic model(input int s, input logic [31:0] v, output int nb,
                         output logic [1:0] k [2], output logic [15:0] im [2], output logic l [2]);
        int    sv;
        bit    fits_s;
        bit    fits_z;
        sv     = int'(v);
        fits_s = (sv >= -32768) && (sv <= 32767);
        fits_z = (s == 0) && (v < 32'd65536);
        k[1] = 2'b00; im[1] = 16'h0; l[1] = 1'b0;
        if (fits_s) begin
            nb = 1; k[0] = 2'b00; im[0] = v[15:0]; l[0] = 1'b1;
        end else if (fits_z) begin
            nb = 1; k[0] = 2'b10; im[0] = v[15:0]; l[0] = 1'b1;
        end else if (v % 32'd65536 == 0) begin
            nb = 1; k[0] = 2'b01; im[0] = 16'(v / 32'd65536); l[0] = 1'b1;
        end else begin
            nb = 2;
            k[0] = 2'b01; im[0] = 16'(v / 32'd65536); l[0] = 1'b0;
            k[1] = 2'b10; im[1] = 16'(v % 32'd65536); l[1] = 1'b1;
        end
        if (!fits_s && !fits_z) begin
            cnt_model[s] = (cnt_model[s] < 3) ? cnt_model[s] + 1 : 3;
        end
    endtask

    // Called and returning just after a falling edge.
    task automatic run_value(input int s, input logic [31:0] v, input int st1, input int st2);
        int          nb;
        int          t;
        int          st;
        logic [1:0]  k  [2];
        logic [15:0] im [2];
        logic        l  [2];
        logic [31:0] recon;
        t = 0;
        while (!in_ready[s] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_idle", 32'(in_ready[s]), 32'd1);
        in_valid[s]  = 1'b1;
        in_value[s]  = v;
        out_ready[s] = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid[s] = 1'b0;
        in_value[s] = $urandom;
        model(s, v, nb, k, im, l);
        chk("out_valid_latency", 32'(out_valid[s]), 32'd1);
        chk("in_ready_busy", 32'(in_ready[s]), 32'd0);
        recon = 32'h0;
        for (int b = 0; b < nb; b++) begin
            st = (b == 0) ? st1 : st2;
            for (int c = 0; c < st; c++) begin
                out_ready[s] = 1'b0;
                in_valid[s]  = 1'b1;
                in_value[s]  = $urandom;
                @(negedge clk);
                in_valid[s] = 1'b0;
                chk("stall_valid", 32'(out_valid[s]), 32'd1);
                chk("stall_imm", 32'(out_imm[s]), 32'(im[b]));
                chk("stall_kind", 32'(out_kind[s]), 32'(k[b]));
                chk("stall_last", 32'(out_last[s]), 32'(l[b]));
            end
            out_ready[s] = 1'b1;
            chk("beat_valid", 32'(out_valid[s]), 32'd1);
            chk("beat_imm", 32'(out_imm[s]), 32'(im[b]));
            chk("beat_kind", 32'(out_kind[s]), 32'(k[b]));
            chk("beat_last", 32'(out_last[s]), 32'(l[b]));
            case (out_kind[s])
                2'b00:   recon = {{16{out_imm[s][15]}}, out_imm[s]};
                2'b01:   recon = {out_imm[s], 16'h0};
                default: recon = recon | {16'h0, out_imm[s]};
            endcase
            @(negedge clk);
        end
        out_ready[s] = 1'($urandom_range(0, 1));
        chk("done_out_valid", 32'(out_valid[s]), 32'd0);
        chk("done_in_ready", 32'(in_ready[s]), 32'd1);
        chk("reconstruct", recon, v);
        chk("split_cnt", 32'(split_cnt[s]), 32'(cnt_model[s]));
    endtask

    task automatic check_reset_state(input int s);
        chk("rst_in_ready", 32'(in_ready[s]), 32'd1);
        chk("rst_out_valid", 32'(out_valid[s]), 32'd0);
        chk("rst_out_imm", 32'(out_imm[s]), 32'd0);
        chk("rst_out_kind", 32'(out_kind[s]), 32'd0);
        chk("rst_out_last", 32'(out_last[s]), 32'd0);
        chk("rst_split_cnt", 32'(split_cnt[s]), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] v;
        n_vec = 0;
        n_bad = 0;
        cnt_model[0] = 0;
        cnt_model[1] = 0;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0; in_value[s] = 32'h0; out_ready[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_value(0, 32'hFFFF8000, 0, 0);
        run_value(0, 32'h00008000, 0, 0);
        run_value(1, 32'h00008000, 0, 0);
        run_value(0, 32'h12345678, 3, 0);
        run_value(0, 32'h12340000, 1, 0);
        run_value(1, 32'h00007FFF, 0, 0);
        run_value(1, 32'h80000000, 0, 0);
        run_value(0, 32'h0000FFFF, 0, 0);

        // Reset while the first beat of a FULL value is pending.
        in_valid[0]  = 1'b1;
        in_value[0]  = 32'hDEADBEEF;
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("mid_emit1_valid", 32'(out_valid[0]), 32'd1);
        rst_n        = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        cnt_model[0] = 0;
        cnt_model[1] = 0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_beat", 32'(out_valid[0]), 32'd0);
        end

        // Saturation: split_cnt must read 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            run_value(0, 32'h12345678 + 32'(i), 0, 0);
        end

        // Random mix across all classes, both instances.
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0:       v = {{16{r[15]}}, r[15:0]};
                1:       v = {16'h0, r[15:0]};
                2:       v = {r[15:0], 16'h0};
                default: v = $urandom;
            endcase
            run_value(i % 2, v, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
